// File: rtl/lsu_mem_controller_pkg.sv
// Shared state encodings, funct3 constants and fault causes for the LSU memory controller.
package lsu_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT  = ST_WAIT,
      DONE  = ST_DONE
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_TIMEOUT  = 2'b10,
      CAUSE_FUNCT3   = 2'b11
   } lsu_cause_e;

   // Stores have no unsigned variants, so only B/H/W are legal for them.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) begin
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_mem_controller_if.sv
// Single-port data-memory bus: valid/ready request channel plus rvalid read-response channel.
interface lsu_mem_controller_if;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_mem_controller_load_align.sv
// Selects the addressed byte/halfword from a raw memory word and sign- or zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] raw_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data_o = {24'd0, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data_o = {16'd0, half_sel};
         default: data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_controller.sv
// MEM-stage load/store sequencer: legality check, store lane steering, bus handshake,
// timeout and load extension, holding the pipeline until a single response is produced.
module lsu_mem_controller
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid_i,
   input  logic                 req_we_i,
   input  logic [2:0]           req_funct3_i,
   input  logic [31:0]          req_addr_i,
   input  logic [31:0]          req_wdata_i,
   output logic                 stall_o,
   output logic                 rsp_valid_o,
   output logic [31:0]          rsp_rdata_o,
   output logic                 rsp_fault_o,
   output logic [1:0]           rsp_cause_o,
   lsu_mem_controller_if.master mem
);

   logic [1:0]      state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            fault_q, fault_d;
   lsu_cause_e      cause_q, cause_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]      strb_q, strb_d;
   logic [2:0]      f3_q, f3_d;
   logic            we_q, we_d;

   lsu_cause_e      req_cause;
   logic [3:0]      st_strb;
   logic [31:0]     st_data;
   logic [31:0]     load_ext;
   logic            to_hit;

   // Illegal funct3 outranks misalignment.
   always_comb begin
      if (!f3_legal(req_we_i, req_funct3_i)) begin
         req_cause = CAUSE_FUNCT3;
      end else if (((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00))) begin
         req_cause = CAUSE_MISALIGN;
      end else begin
         req_cause = CAUSE_NONE;
      end
   end

   always_comb begin
      st_strb = 4'b0000;
      st_data = '0;
      if (req_we_i) begin
         case (req_funct3_i)
            F3_B: begin
               st_strb = 4'b0001 << req_addr_i[1:0];
               st_data = {24'd0, req_wdata_i[7:0]} << {req_addr_i[1:0], 3'b000};
            end
            F3_H: begin
               st_strb = req_addr_i[1] ? 4'b1100 : 4'b0011;
               st_data = req_addr_i[1] ? {req_wdata_i[15:0], 16'd0} : {16'd0, req_wdata_i[15:0]};
            end
            default: begin
               st_strb = 4'b1111;
               st_data = req_wdata_i;
            end
         endcase
      end
   end

   lsu_load_align u_align (
      .raw_i    (mem.mem_rdata),
      .off_i    (addr_q[1:0]),
      .funct3_i (f3_q),
      .data_o   (load_ext)
   );

   assign to_hit = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      cause_d = cause_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      f3_d    = f3_q;
      we_d    = we_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && (req_cause == CAUSE_NONE)) begin
               state_d = ST_ISSUE;
               cnt_d   = '0;
               addr_d  = req_addr_i;
               wdata_d = st_data;
               strb_d  = st_strb;
               f3_d    = req_funct3_i;
               we_d    = req_we_i;
            end else if (req_valid_i) begin
               state_d = ST_DONE;
               fault_d = 1'b1;
               cause_d = req_cause;
               rdata_d = '0;
            end
         end
         ST_ISSUE: begin
            cnt_d = cnt_q + TO_W'(1);
            if (mem.mem_ready && we_q) begin
               state_d = ST_DONE;
               fault_d = 1'b0;
               cause_d = CAUSE_NONE;
               rdata_d = '0;
            end else if (mem.mem_ready) begin
               state_d = ST_WAIT;
            end else if (to_hit) begin
               state_d = ST_DONE;
               fault_d = 1'b1;
               cause_d = CAUSE_TIMEOUT;
               rdata_d = '0;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + TO_W'(1);
            if (mem.mem_rvalid) begin
               state_d = ST_DONE;
               fault_d = 1'b0;
               cause_d = CAUSE_NONE;
               rdata_d = load_ext;
            end else if (to_hit) begin
               state_d = ST_DONE;
               fault_d = 1'b1;
               cause_d = CAUSE_TIMEOUT;
               rdata_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         cause_q <= CAUSE_NONE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
         rdata_q <= rdata_d;
      end
   end

   // Request fields are only meaningful while ISSUE/WAIT, so they carry no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
   end

   assign stall_o     = ((state_q == ST_IDLE) && req_valid_i) || (state_q == ST_ISSUE) ||
                        (state_q == ST_WAIT);
   assign rsp_valid_o = (state_q == ST_DONE);
   assign rsp_rdata_o = rdata_q;
   assign rsp_fault_o = fault_q;
   assign rsp_cause_o = cause_q;

   assign mem.mem_valid = (state_q == ST_ISSUE);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = {addr_q[31:2], 2'b00};
   assign mem.mem_wstrb = strb_q;
   assign mem.mem_wdata = wdata_q;

endmodule
